// File: rtl/frame_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sync_ctrl_pkg
//  Description : Shared constants and types for the frame-synchronous scene
//                scheduler: default video timing, coordinate and scene-field
//                widths, the scene payload record and the two FSM encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package frame_sync_ctrl_pkg;

    // Default video timing (lines / pixels)
    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_TOTAL_DEF  = 666;

    // Scene field widths
    localparam int COORD_W   = 11;
    localparam int SQUEEZE_W = 4;
    localparam int TYPE_W    = 2;

    // Scheduler states; ST_FULL doubles as the "pending buffer full" flag
    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;

    // One complete scene update as handed over by the game FSM
    typedef struct packed {
        logic [COORD_W-1:0]   x_block1;
        logic [COORD_W-1:0]   x_block2;
        logic [COORD_W-1:0]   x_man;
        logic [COORD_W-1:0]   y_man;
        logic                 en_block1;
        logic                 en_block2;
        logic                 title;
        logic                 gameover;
        logic [SQUEEZE_W-1:0] squeeze_man;
        logic [TYPE_W-1:0]    type_block1;
        logic [TYPE_W-1:0]    type_block2;
    } scene_t;

    // Power-up scene: everything cleared except the title screen
    function automatic scene_t scene_powerup();
        scene_t s;
        s       = '0;
        s.title = 1'b1;
        return s;
    endfunction

endpackage : frame_sync_ctrl_pkg
`default_nettype wire

// File: rtl/frame_sync_ctrl_scene_regs.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sync_ctrl_scene_regs
//  Description : Scene payload register bank with load enable and a
//                parameterised asynchronous reset value. Used both as the
//                pending buffer and as the renderer-facing shadow bank.
//  Ports       : clk     - clock
//                rst     - asynchronous reset, active-high (loads RST_VAL)
//                i_load  - capture i_d on the next clock edge
//                i_d     - scene payload in
//                o_q     - registered scene payload out
//  Revision    : 1.0  initial release
// ============================================================================
module frame_sync_ctrl_scene_regs
    import frame_sync_ctrl_pkg::*;
#(
    parameter scene_t RST_VAL = '0
)(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  scene_t i_d,
    output scene_t o_q
);

    scene_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : frame_sync_ctrl_scene_regs
`default_nettype wire

// File: rtl/frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sync_ctrl
//  Description : Frame-synchronous scheduler between the game FSM and the
//                renderer. One scene update is accepted over a valid/ready
//                handshake into a pending buffer and is committed to the
//                renderer-facing outputs only at vertical-blank entry, so a
//                frame is never drawn from mixed old/new state.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                i_y_read            - current scan line from the VGA timing
//                i_upd_valid/o_upd_ready - update handshake
//                i_<field>           - update payload
//                o_<field>           - committed scene state
//                o_frame_tick        - one-cycle pulse after vblank entry
//                o_frame_cnt         - frames since reset (wrapping)
//                o_stall_cnt         - saturating count of stalled cycles
//  Options     : STALL_CNT_EN - when defined, o_stall_cnt counts cycles with
//                i_upd_valid && !o_upd_ready (saturating at 255); otherwise
//                it is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_sync_ctrl
    import frame_sync_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int FCNT_W   = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COORD_W-1:0]   i_y_read,
    input  logic                 i_upd_valid,
    output logic                 o_upd_ready,
    input  logic [COORD_W-1:0]   i_x_block1,
    input  logic [COORD_W-1:0]   i_x_block2,
    input  logic [COORD_W-1:0]   i_x_man,
    input  logic [COORD_W-1:0]   i_y_man,
    input  logic                 i_en_block1,
    input  logic                 i_en_block2,
    input  logic                 i_title,
    input  logic                 i_gameover,
    input  logic [SQUEEZE_W-1:0] i_squeeze_man,
    input  logic [TYPE_W-1:0]    i_type_block1,
    input  logic [TYPE_W-1:0]    i_type_block2,
    output logic [COORD_W-1:0]   o_x_block1,
    output logic [COORD_W-1:0]   o_x_block2,
    output logic [COORD_W-1:0]   o_x_man,
    output logic [COORD_W-1:0]   o_y_man,
    output logic                 o_en_block1,
    output logic                 o_en_block2,
    output logic                 o_title,
    output logic                 o_gameover,
    output logic [SQUEEZE_W-1:0] o_squeeze_man,
    output logic [TYPE_W-1:0]    o_type_block1,
    output logic [TYPE_W-1:0]    o_type_block2,
    output logic                 o_frame_tick,
    output logic [FCNT_W-1:0]    o_frame_cnt,
    output logic [7:0]           o_stall_cnt
);

    localparam logic [COORD_W-1:0] C_V_ACTIVE = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] C_V_TOTAL  = COORD_W'(V_TOTAL);

    // Reject timing that cannot describe a real frame
    if ((H_ACTIVE <= 0) || (V_ACTIVE <= 0) || (V_TOTAL <= V_ACTIVE) ||
        (V_TOTAL >= (1 << COORD_W))) begin : g_bad_cfg
        $error("frame_sync_ctrl: inconsistent video timing parameters");
    end

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_upd_ready;
    logic              r_vb_d;
    logic              r_frame_tick;
    logic [FCNT_W-1:0] r_frame_cnt;

    logic   w_vb;
    logic   w_vb_entry;
    logic   w_handshake;
    logic   w_load_pend;
    logic   w_commit;
    scene_t w_upd;
    scene_t w_pend;
    scene_t w_shadow;

    // ------------------------------------------------------------------
    // Vertical blank detection. Out-of-range lines (>= V_TOTAL) are
    // treated as blank too, so a glitching y never opens a visible window.
    // ------------------------------------------------------------------
    assign w_vb       = (i_y_read >= C_V_ACTIVE) || (i_y_read >= C_V_TOTAL);
    assign w_vb_entry = w_vb && !r_vb_d;
    assign w_handshake = i_upd_valid && r_upd_ready;

    // ------------------------------------------------------------------
    // Scheduler FSM. ACTIVE = pending empty, FULL = pending holds an
    // update waiting for the next vblank entry.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_pend = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                // Also taken on the vblank-entry cycle itself: the update
                // then waits a full frame, never committing mid-entry.
                if (w_handshake) begin
                    w_load_pend = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_vb_entry) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // vb_d resets high so releasing reset inside blank is not an entry.
    // ready resets low and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ACTIVE;
            r_upd_ready  <= 1'b0;
            r_vb_d       <= 1'b1;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_upd_ready  <= (w_state_nxt == ST_ACTIVE);
            r_vb_d       <= w_vb;
            r_frame_tick <= w_vb_entry;
            if (w_vb_entry) begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload banks: pending (captured on handshake) and shadow
    // (captured from pending on vblank entry).
    // ------------------------------------------------------------------
    always_comb begin
        w_upd             = '0;
        w_upd.x_block1    = i_x_block1;
        w_upd.x_block2    = i_x_block2;
        w_upd.x_man       = i_x_man;
        w_upd.y_man       = i_y_man;
        w_upd.en_block1   = i_en_block1;
        w_upd.en_block2   = i_en_block2;
        w_upd.title       = i_title;
        w_upd.gameover    = i_gameover;
        w_upd.squeeze_man = i_squeeze_man;
        w_upd.type_block1 = i_type_block1;
        w_upd.type_block2 = i_type_block2;
    end

    frame_sync_ctrl_scene_regs #(
        .RST_VAL ('0)
    ) u_pending (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_pend),
        .i_d    (w_upd),
        .o_q    (w_pend)
    );

    frame_sync_ctrl_scene_regs #(
        .RST_VAL (scene_powerup())
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_commit),
        .i_d    (w_pend),
        .o_q    (w_shadow)
    );

    assign o_x_block1    = w_shadow.x_block1;
    assign o_x_block2    = w_shadow.x_block2;
    assign o_x_man       = w_shadow.x_man;
    assign o_y_man       = w_shadow.y_man;
    assign o_en_block1   = w_shadow.en_block1;
    assign o_en_block2   = w_shadow.en_block2;
    assign o_title       = w_shadow.title;
    assign o_gameover    = w_shadow.gameover;
    assign o_squeeze_man = w_shadow.squeeze_man;
    assign o_type_block1 = w_shadow.type_block1;
    assign o_type_block2 = w_shadow.type_block2;

    assign o_upd_ready  = r_upd_ready;
    assign o_frame_tick = r_frame_tick;
    assign o_frame_cnt  = r_frame_cnt;

    // ------------------------------------------------------------------
    // Stall statistic
    // ------------------------------------------------------------------
`ifdef STALL_CNT_EN
    logic [7:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 8'd0;
        end else if (i_upd_valid && !r_upd_ready && (r_stall_cnt != 8'hFF)) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 8'd0;
`endif

endmodule : frame_sync_ctrl
`default_nettype wire

// File: tb/tb_frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sync_ctrl
//  Description : Self-checking bench for frame_sync_ctrl. A behavioural
//                model (one-slot pending queue, committed scene, counters)
//                is advanced every cycle and compared against the DUT on the
//                falling edge; directed sections add literal expectations.
//                The frame counter is narrowed to 8 bits to exercise wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_sync_ctrl;

    localparam int FCNT_W = 8;

    typedef struct packed {
        logic [10:0] xb1;
        logic [10:0] xb2;
        logic [10:0] xm;
        logic [10:0] ym;
        logic        eb1;
        logic        eb2;
        logic        title;
        logic        go;
        logic [3:0]  sq;
        logic [1:0]  t1;
        logic [1:0]  t2;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] y = 11'd620;
    logic        valid = 1'b0;
    pay_t        din = '0;

    logic [10:0] o_xb1, o_xb2, o_xm, o_ym;
    logic        o_eb1, o_eb2, o_title, o_go;
    logic [3:0]  o_sq;
    logic [1:0]  o_t1, o_t2;
    logic        o_ready, o_tick;
    logic [FCNT_W-1:0] o_cnt;
    logic [7:0]  o_stall;
    pay_t        dout;

    assign dout = {o_xb1, o_xb2, o_xm, o_ym, o_eb1, o_eb2, o_title, o_go, o_sq, o_t1, o_t2};

    always #5 clk = ~clk;

    frame_sync_ctrl #(.FCNT_W(FCNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_y_read      (y),
        .i_upd_valid   (valid),
        .o_upd_ready   (o_ready),
        .i_x_block1    (din.xb1),
        .i_x_block2    (din.xb2),
        .i_x_man       (din.xm),
        .i_y_man       (din.ym),
        .i_en_block1   (din.eb1),
        .i_en_block2   (din.eb2),
        .i_title       (din.title),
        .i_gameover    (din.go),
        .i_squeeze_man (din.sq),
        .i_type_block1 (din.t1),
        .i_type_block2 (din.t2),
        .o_x_block1    (o_xb1),
        .o_x_block2    (o_xb2),
        .o_x_man       (o_xm),
        .o_y_man       (o_ym),
        .o_en_block1   (o_eb1),
        .o_en_block2   (o_eb2),
        .o_title       (o_title),
        .o_gameover    (o_go),
        .o_squeeze_man (o_sq),
        .o_type_block1 (o_t1),
        .o_type_block2 (o_t2),
        .o_frame_tick  (o_tick),
        .o_frame_cnt   (o_cnt),
        .o_stall_cnt   (o_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    pay_t m_pend_q[$];     // at most one waiting update
    pay_t m_out;
    bit   m_ready, m_tick, m_prev_blank;
    int   m_frames, m_stall;

    task automatic model_reset();
        m_pend_q.delete();
        m_out        = '0;
        m_out.title  = 1'b1;
        m_ready      = 1'b0;
        m_tick       = 1'b0;
        m_prev_blank = 1'b1;
        m_frames     = 0;
        m_stall      = 0;
    endtask

    task automatic model_step();
        bit blank;
        bit entry;
        blank = (y >= 11'd600);
        entry = blank && !m_prev_blank;
`ifdef STALL_CNT_EN
        if (valid && !m_ready && m_stall < 255) m_stall++;
`endif
        if (entry && m_pend_q.size() != 0) begin
            m_out = m_pend_q.pop_front();
        end else if (valid && m_ready) begin
            m_pend_q.push_back(din);
        end
        m_ready      = (m_pend_q.size() == 0);
        m_tick       = entry;
        if (entry) m_frames++;
        m_prev_blank = blank;
    endtask

    // Single compare process: outputs reflect the last rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("scene", dout, m_out);
            chk("ready", o_ready, m_ready);
            chk("tick", o_tick, m_tick);
            chk("frame_cnt", o_cnt, m_frames % (1 << FCNT_W));
            chk("stall_cnt", o_stall, m_stall);
            if (!rst) model_step();
        end
    end

    // Tick monitor for the wrap test
    int nticks = 0;
    initial forever begin
        @(negedge clk);
        if (!rst && o_tick) nticks++;
    end

    // ---------------- stimulus helpers ----------------
    int   feed_idx = 0;
    bit   feed_on  = 1'b0;
    logic [10:0] feed_vals [3];

    task automatic cyc();
        bit fire;
        fire = valid && o_ready;
        @(posedge clk);
        #1;
        if (feed_on && fire) begin
            feed_idx++;
            if (feed_idx < 3) din.xm = feed_vals[feed_idx];
            else begin
                valid   = 1'b0;
                feed_on = 1'b0;
            end
        end
    endtask

    task automatic frame(input int vis, input int blk);
        for (int i = 0; i < vis; i++) begin
            y = 11'($urandom_range(0, 599));
            cyc();
        end
        for (int i = 0; i < blk; i++) begin
            if ($urandom_range(0, 9) == 0) y = 11'($urandom_range(666, 2047));
            else                           y = 11'($urandom_range(600, 665));
            cyc();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        int ypos;

        // 1: reset inside blank, no spurious tick
        rst = 1'b1; y = 11'd620; valid = 1'b0; din = '0;
        repeat (3) cyc();
        chk("rst_title", o_title, 1'b1);
        chk("rst_xman", o_xm, 11'd0);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_cnt", o_cnt, 0);
        rst = 1'b0;
        cyc();
        chk("ready_after_release", o_ready, 1'b1);
        repeat (3) begin
            cyc();
            chk("no_tick_in_blank", o_tick, 1'b0);
        end
        y = 11'd100; cyc();
        y = 11'd599; cyc();
        y = 11'd600; cyc();
        chk("first_tick", o_tick, 1'b1);
        chk("first_cnt", o_cnt, 1);

        // 2: basic handshake and commit at vblank entry
        y = 11'd100; din = '0; din.xm = 11'd400; din.eb1 = 1'b1; valid = 1'b1;
        cyc();
        valid = 1'b0;
        chk("ready_drop", o_ready, 1'b0);
        for (int v = 150; v < 600; v += 75) begin
            y = 11'(v);
            cyc();
        end
        y = 11'd599; cyc();
        chk("xman_held", o_xm, 11'd0);
        y = 11'd600; cyc();
        chk("xman_commit", o_xm, 11'd400);
        chk("eb1_commit", o_eb1, 1'b1);
        chk("commit_tick", o_tick, 1'b1);
        chk("ready_back", o_ready, 1'b1);

        // 3: held valid, one commit per frame in order
        feed_vals[0] = 11'd300; feed_vals[1] = 11'd400; feed_vals[2] = 11'd500;
        feed_idx = 0; feed_on = 1'b1;
        y = 11'd100; din.xm = 11'd300; valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame(20, 5);
            chk("held_commit", o_xm, feed_vals[f]);
        end
        chk("feed_done", feed_idx, 3);
        valid = 1'b0; feed_on = 1'b0;
`ifdef STALL_CNT_EN
        chk("stall_counted", (o_stall > 8'd0), 1'b1);
`else
        chk("stall_tied", o_stall, 8'd0);
`endif

        // 4: handshake on the vblank-entry cycle waits a whole frame
        y = 11'd599; cyc();
        y = 11'd600; din.xm = 11'd250; valid = 1'b1;
        chk("ready_at_entry", o_ready, 1'b1);
        cyc();
        valid = 1'b0;
        chk("entry_hs_not_shown", o_xm, 11'd500);
        chk("entry_hs_full", o_ready, 1'b0);
        repeat (3) cyc();
        frame(10, 3);
        chk("entry_hs_next_frame", o_xm, 11'd250);

        // 5: frame counter wrap
        rst = 1'b1; y = 11'd620; cyc();
        rst = 1'b0; cyc();
        nticks = 0;
        for (int f = 0; f < (1 << FCNT_W) + 1; f++) frame(1, 1);
        cyc();
        chk("cnt_wrap", o_cnt, 1);
        chk("tick_total", nticks, (1 << FCNT_W) + 1);

        // 6: async reset while FULL discards the pending update
        y = 11'd200; din.xm = 11'd777; valid = 1'b1; cyc();
        valid = 1'b0; y = 11'd300; cyc();
        chk("full_before_rst", o_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_xman", o_xm, 11'd0);
        chk("async_rst_title", o_title, 1'b1);
        chk("async_rst_ready", o_ready, 1'b0);
        chk("async_rst_cnt", o_cnt, 0);
        cyc(); cyc();
        rst = 1'b0;
        frame(5, 3);
        frame(5, 3);
        chk("discarded", o_xm, 11'd0);
        chk("ready_post_rst", o_ready, 1'b1);

        // 7: randomized traffic with occasional async reset
        ypos = 0;
        for (int c = 0; c < 3000; c++) begin
            valid = ($urandom_range(0, 9) < 6);
            rnd   = {$urandom(), $urandom()};
            din   = rnd[55:0];
            if ($urandom_range(0, 199) == 0) ypos = $urandom_range(666, 2047);
            else begin
                ypos = ypos + $urandom_range(1, 40);
                if (ypos >= 666) ypos = 0;
            end
            y = 11'(ypos);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end
        valid = 1'b0;
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_frame_sync_ctrl
`default_nettype wire
